// File: rtl/nco_phase_sine_gen.sv
// rtl/nco_phase_sine_gen.sv - tick-driven phase accumulator NCO with pipelined quarter-wave sine LUT
module nco_phase_sine_gen #(
   parameter int ACC_WIDTH      = 24,
   parameter int LUT_ADDR_WIDTH = 8,
   parameter int OUT_WIDTH      = 12
) (
   input  logic                        clk_in,
   input  logic                        rst,
   input  logic                        sample_tick_in,
   input  logic [ACC_WIDTH-1:0]        fcw_in,
   input  logic                        fcw_valid,
   output logic                        fcw_ready,
   output logic [ACC_WIDTH-1:0]        phase_out,
   output logic signed [OUT_WIDTH-1:0] sine_out,
   output logic                        sine_valid
);

   localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
   localparam int AMP       = (1 << (OUT_WIDTH - 1)) - 1;

   // Half-index offset keeps every entry strictly positive and below AMP+1,
   // so the quadrant negation can never hit the most-negative code.
   function automatic logic [OUT_WIDTH-1:0] lut_entry(input int idx);
      real ang;
      ang = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / real'(LUT_DEPTH);
      return OUT_WIDTH'($rtoi(real'(AMP) * $sin(ang) + 0.5));
   endfunction

   logic [OUT_WIDTH-1:0] lut_rom [LUT_DEPTH];

   for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
      assign lut_rom[g] = lut_entry(g);
   end

   logic                      tick_q, tick_d;
   logic [ACC_WIDTH-1:0]      phase_q, phase_d;
   logic [ACC_WIDTH-1:0]      active_fcw_q, active_fcw_d;
   logic [ACC_WIDTH-1:0]      shadow_fcw_q, shadow_fcw_d;
   logic                      pending_q, pending_d;
   logic                      fcw_ready_q, fcw_ready_d;
   logic                      s1_valid_q, s1_valid_d;
   logic                      s1_neg_q, s1_neg_d;
   logic [LUT_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic                      s2_valid_q, s2_valid_d;
   logic                      s2_neg_q, s2_neg_d;
   logic [OUT_WIDTH-1:0]      s2_mag_q, s2_mag_d;
   logic                      sine_valid_q, sine_valid_d;
   logic [OUT_WIDTH-1:0]      sine_q, sine_d;

   logic                      tick_evt;
   logic                      fcw_xfer;
   logic [1:0]                quad;
   logic [LUT_ADDR_WIDTH-1:0] addr;

   // Next-state: edge detect, FCW double-buffering, accumulate and the three pipeline stages
   always_comb begin
      tick_evt     = sample_tick_in & ~tick_q;
      fcw_xfer     = fcw_valid & fcw_ready_q & ~pending_q;

      tick_d       = sample_tick_in;
      phase_d      = phase_q;
      active_fcw_d = active_fcw_q;
      shadow_fcw_d = shadow_fcw_q;
      pending_d    = pending_q;

      // Promotion uses the old word for this event; the new one takes effect next event.
      if (tick_evt) begin
         phase_d = phase_q + active_fcw_q;
         if (pending_q) begin
            active_fcw_d = shadow_fcw_q;
            pending_d    = 1'b0;
         end
      end
      // A transfer colliding with an event is only promoted at the following event.
      if (fcw_xfer) begin
         shadow_fcw_d = fcw_in;
         pending_d    = 1'b1;
      end
      fcw_ready_d = ~pending_d;

      // S1 works from the freshly accumulated phase so the strobe lands at event+3.
      quad = phase_d[ACC_WIDTH-1 -: 2];
      addr = phase_d[ACC_WIDTH-3 -: LUT_ADDR_WIDTH];
      if (quad[0]) begin
         addr = ~addr;
      end
      s1_valid_d = tick_evt;
      s1_neg_d   = s1_neg_q;
      s1_addr_d  = s1_addr_q;
      if (tick_evt) begin
         s1_neg_d  = quad[1];
         s1_addr_d = addr;
      end

      s2_valid_d = s1_valid_q;
      s2_neg_d   = s2_neg_q;
      s2_mag_d   = s2_mag_q;
      if (s1_valid_q) begin
         s2_neg_d = s1_neg_q;
         s2_mag_d = lut_rom[s1_addr_q];
      end

      sine_valid_d = s2_valid_q;
      sine_d       = sine_q;
      if (s2_valid_q) begin
         sine_d = s2_neg_q ? (~s2_mag_q + 1'b1) : s2_mag_q;
      end
   end

   // State registers; tick_q resets high so a level already high at release is not an event
   always_ff @(posedge clk_in) begin
      if (rst) begin
         tick_q       <= 1'b1;
         phase_q      <= '0;
         active_fcw_q <= '0;
         shadow_fcw_q <= '0;
         pending_q    <= 1'b0;
         fcw_ready_q  <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_neg_q     <= 1'b0;
         s1_addr_q    <= '0;
         s2_valid_q   <= 1'b0;
         s2_neg_q     <= 1'b0;
         s2_mag_q     <= '0;
         sine_valid_q <= 1'b0;
         sine_q       <= '0;
      end else begin
         tick_q       <= tick_d;
         phase_q      <= phase_d;
         active_fcw_q <= active_fcw_d;
         shadow_fcw_q <= shadow_fcw_d;
         pending_q    <= pending_d;
         fcw_ready_q  <= fcw_ready_d;
         s1_valid_q   <= s1_valid_d;
         s1_neg_q     <= s1_neg_d;
         s1_addr_q    <= s1_addr_d;
         s2_valid_q   <= s2_valid_d;
         s2_neg_q     <= s2_neg_d;
         s2_mag_q     <= s2_mag_d;
         sine_valid_q <= sine_valid_d;
         sine_q       <= sine_d;
      end
   end

   assign fcw_ready  = fcw_ready_q;
   assign phase_out  = phase_q;
   assign sine_out   = sine_q;
   assign sine_valid = sine_valid_q;

endmodule
